// File: rtl/halt_pkg.sv
// rtl/halt_pkg.sv - shared state, cause encodings and default HALT opcode for the halt interface
package halt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_REQ    = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_OPCODE  = 2'b01,
    CAUSE_DEBUG   = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_t;

  // Shared with the decoder so both sides agree on the HALT encoding.
  localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'hF;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear that holds at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/halt_controller.sv
// rtl/halt_controller.sv - halt initiator: stall fetch, drain, request halt; HALT_TIMEOUT_EN adds a REQ timeout
module halt_controller
  import halt_pkg::*;
#(
  parameter int                    OPCODE_W     = 4,
  parameter logic [OPCODE_W-1:0]   HALT_OPCODE  = OPCODE_W'(HALT_OPCODE_DEFAULT),
  parameter int                    DRAIN_CYCLES = 3,
  parameter int                    CNT_W        = 32,
  parameter int                    TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] instr_opcode,
  input  logic                dbg_halt_req,
  input  logic                program_halted,
  output logic                fetch_en,
  output logic                halt_signal,
  output logic                running,
  output logic [1:0]          halt_cause,
  output logic [CNT_W-1:0]    run_cycles
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || TIMEOUT < 1) begin : g_param_check
    $error("halt_controller: DRAIN_CYCLES must be 1..15 and TIMEOUT >= 1");
  end

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t     state;
  cause_t     cause_q;
  logic [3:0] drain_cnt;
  logic       halt_op;

  assign halt_op    = instr_valid && (instr_opcode == HALT_OPCODE);
  assign halt_cause = cause_q;

  // Cleared only on a cold start from IDLE; a resume from HALTED keeps counting.
  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == ST_IDLE) && start),
    .en    (state == ST_RUN),
    .count (run_cycles)
  );

`ifdef HALT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_count;
  logic             tmo_hit;

  // Held at zero outside REQ, so it restarts on every REQ entry.
  sat_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_REQ),
    .en    (state == ST_REQ),
    .count (tmo_count)
  );

  assign tmo_hit = (tmo_count == TMO_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fetch_en    <= 1'b0;
      halt_signal <= 1'b0;
      running     <= 1'b0;
      cause_q     <= CAUSE_NONE;
      drain_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state    <= ST_RUN;
            fetch_en <= 1'b1;
            running  <= 1'b1;
            cause_q  <= CAUSE_NONE;
          end
        end

        ST_RUN: begin
          // The HALT opcode takes precedence over a simultaneous debug request.
          if (halt_op || dbg_halt_req) begin
            state     <= ST_DRAIN;
            fetch_en  <= 1'b0;
            running   <= 1'b0;
            drain_cnt <= DRAIN_INIT;
            cause_q   <= halt_op ? CAUSE_OPCODE : CAUSE_DEBUG;
          end
        end

        ST_DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state       <= ST_REQ;
            halt_signal <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end

        ST_REQ: begin
          if (program_halted) begin
            state       <= ST_HALTED;
            halt_signal <= 1'b0;
          end
`ifdef HALT_TIMEOUT_EN
          else if (tmo_hit) begin
            state       <= ST_HALTED;
            halt_signal <= 1'b0;
            cause_q     <= CAUSE_TIMEOUT;
          end
`endif
        end

        default: begin
          state       <= ST_IDLE;
          fetch_en    <= 1'b0;
          halt_signal <= 1'b0;
          running     <= 1'b0;
          cause_q     <= CAUSE_NONE;
          drain_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_halt_controller.sv
// tb/tb_halt_controller.sv - scoreboard bench for halt_controller (timeout checks when HALT_TIMEOUT_EN is set)
module tb_halt_controller;

  localparam int D   = 3;
  localparam int TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        instr_valid;
  logic [3:0]  instr_opcode;
  logic        dbg_halt_req;
  logic        program_halted;
  logic        fetch_en;
  logic        halt_signal;
  logic        running;
  logic [1:0]  halt_cause;
  logic [31:0] run_cycles;

  halt_controller #(.DRAIN_CYCLES(D), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .instr_valid    (instr_valid),
    .instr_opcode   (instr_opcode),
    .dbg_halt_req   (dbg_halt_req),
    .program_halted (program_halted),
    .fetch_en       (fetch_en),
    .halt_signal    (halt_signal),
    .running        (running),
    .halt_cause     (halt_cause),
    .run_cycles     (run_cycles)
  );

  typedef struct {
    int         rise;
    logic [1:0] cause;
    int         width;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   hi_cnt   = 0;
  bit   in_flight = 0;
  int   ack_mode = 0;  // 0: follow halt_signal one cycle late, 1: hold 0, 2: hold 1
  logic ph_q = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    ph_q <= halt_signal;
  end

  assign program_halted = (ack_mode == 0) ? ph_q : (ack_mode == 2);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      step();
      n++;
    end
    check("wait_done", done_cnt >= target, 1);
  endtask

  task automatic push(input int rise, input logic [1:0] cause, input int width);
    exp_t e;
    e.rise  = rise;
    e.cause = cause;
    e.width = width;
    sb.push_back(e);
  endtask

  // Monitor: pops an expectation when halt_signal rises, settles it when it falls.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight = 0;
      hi_cnt    = 0;
    end else if (halt_signal) begin
      if (!in_flight) begin
        if (sb.size() == 0) begin
          check("unexpected_halt", 1, 0);
        end else begin
          cur = sb.pop_front();
          check("halt_rise_cycle", cyc, cur.rise);
        end
        in_flight = 1;
        hi_cnt    = 0;
      end
      hi_cnt++;
    end else if (in_flight) begin
      in_flight = 0;
      check("halt_width", hi_cnt, cur.width);
      check("halt_cause_at_halt", halt_cause, cur.cause);
      check("halted_outputs_idle", {fetch_en, running}, 2'b00);
      done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; instr_valid = 1'b0; instr_opcode = 4'h0; dbg_halt_req = 1'b0;
    step(); step();
    check("rst_fetch_en", fetch_en, 0);
    check("rst_halt_signal", halt_signal, 0);
    check("rst_running", running, 0);
    check("rst_halt_cause", halt_cause, 0);
    check("rst_run_cycles", run_cycles, 0);
    rst_n = 1'b1;
    step();
    check("idle_no_start", running, 0);

    // Cold start and run-cycle counting
    start = 1'b1; step(); start = 1'b0;
    check("start_running", running, 1);
    check("start_fetch_en", fetch_en, 1);
    check("start_run_cycles", run_cycles, 0);
    repeat (5) step();
    check("run_cycles_5", run_cycles, 5);
    start = 1'b1; step(); start = 1'b0;
    check("start_in_run_ignored", run_cycles, 6);
    instr_valid = 1'b1; instr_opcode = 4'h3; step();
    instr_valid = 1'b0; instr_opcode = 4'hF; step();
    instr_opcode = 4'h0;
    check("non_halt_still_running", running, 1);
    check("run_cycles_8", run_cycles, 8);

    // HALT opcode, ack follows halt_signal one cycle later
    ack_mode = 0;
    push(cyc + D + 1, 2'b01, 2);
    instr_valid = 1'b1; instr_opcode = 4'hF; step();
    instr_valid = 1'b0; instr_opcode = 4'h0;
    check("drain_fetch_en_low", fetch_en, 0);
    check("drain_not_running", running, 0);
    wait_done(1);
    check("run_cycles_held_9", run_cycles, 9);

    // Resume; opcode and debug together, extra requests during DRAIN, ack already high
    ack_mode = 2;
    start = 1'b1; step(); start = 1'b0;
    check("resume_running", running, 1);
    check("resume_cause_cleared", halt_cause, 0);
    check("resume_keeps_count", run_cycles, 9);
    push(cyc + D + 1, 2'b01, 1);
    instr_valid = 1'b1; instr_opcode = 4'hF; dbg_halt_req = 1'b1;
    step(); step();
    instr_valid = 1'b0; instr_opcode = 4'h0; dbg_halt_req = 1'b0;
    wait_done(2);
    check("run_cycles_10", run_cycles, 10);

    // Start with debug request still high: one RUN cycle, then DRAIN
    push(cyc + D + 2, 2'b10, 1);
    start = 1'b1; dbg_halt_req = 1'b1; step(); start = 1'b0;
    check("start_dbg_run", running, 1);
    step();
    check("start_dbg_drain", fetch_en, 0);
    dbg_halt_req = 1'b0;
    wait_done(3);
    check("run_cycles_11", run_cycles, 11);

    // Asynchronous reset in REQ
    ack_mode = 1;
    start = 1'b1; step(); start = 1'b0;
    push(cyc + D + 1, 2'b01, 0);
    instr_valid = 1'b1; instr_opcode = 4'hF; step();
    instr_valid = 1'b0; instr_opcode = 4'h0;
    repeat (D + 1) step();
    check("req_halt_high", halt_signal, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_halt_signal", halt_signal, 0);
    check("async_rst_fetch_en", fetch_en, 0);
    check("async_rst_cause", halt_cause, 0);
    check("async_rst_run_cycles", run_cycles, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_needs_start", running, 0);

    // Debug halt at run_cycles=20, then resume counting
    ack_mode = 0;
    start = 1'b1; step(); start = 1'b0;
    repeat (19) step();
    push(cyc + D + 1, 2'b10, 2);
    dbg_halt_req = 1'b1; step(); dbg_halt_req = 1'b0;
    wait_done(4);
    check("dbg_run_cycles_20", run_cycles, 20);
    start = 1'b1; step(); start = 1'b0;
    check("dbg_resume_cause", halt_cause, 0);
    check("dbg_resume_20", run_cycles, 20);
    step();
    check("dbg_resume_21", run_cycles, 21);
    step();
    check("dbg_resume_22", run_cycles, 22);

    // No acknowledgment: timeout when enabled, otherwise wait indefinitely
    ack_mode = 1;
`ifdef HALT_TIMEOUT_EN
    push(cyc + D + 1, 2'b11, TMO);
    instr_valid = 1'b1; instr_opcode = 4'hF; step();
    instr_valid = 1'b0; instr_opcode = 4'h0;
    wait_done(5);
    check("timeout_cause", halt_cause, 2'b11);
`else
    push(cyc + D + 1, 2'b01, 101);
    instr_valid = 1'b1; instr_opcode = 4'hF; step();
    instr_valid = 1'b0; instr_opcode = 4'h0;
    repeat (D) step();
    repeat (100) step();
    check("no_timeout_still_req", halt_signal, 1);
    check("no_timeout_cause", halt_cause, 2'b01);
    ack_mode = 2;
    wait_done(5);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
